// File: rtl/serial_add_pkg.sv
// Shared constants and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  // Default operand width when the parent does not override it.
  localparam int DEFAULT_WIDTH = 4;

  // Controller state encoding; 2'b11 is unused and steers back to idle.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_SHIFT = 2'b01;
  localparam state_t ST_DONE  = 2'b10;

  // Majority of three bits: the carry-out of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// Single full-adder cell with a registered carry for LSB-first serial addition.
module serial_fa_bit
  import serial_add_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic load,
  input  logic cin_load,
  input  logic en,
  output logic s,
  output logic carry
);

  // Sum bit uses the carry left behind by the previous bit position.
  assign s = a ^ b ^ carry;

  // Carry is seeded with the external carry-in on load, then ripples one bit per enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (load) begin
      carry <= cin_load;
    end else if (en) begin
      carry <= maj3(a, b, carry);
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for the bit-serial adder: loads operands, shifts them LSB-first
// through one full-adder cell, counts bits and captures the final result.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  // The lowest sum bit would only ever be shifted out, so it is not stored.
  logic [WIDTH-1:1] s_sr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic [WIDTH-1:0] a_shr;
  logic [WIDTH-1:0] b_shr;
  logic [WIDTH-1:0] s_sr_next;
  logic             fa_load;
  logic             fa_en;
  logic             fa_s;
  logic             fa_carry;
  logic             carry_new;
  logic             last_bit;

  assign fa_load   = (state_reg == ST_IDLE) && start;
  assign fa_en     = (state_reg == ST_SHIFT);
  assign last_bit  = fa_en && (cnt_reg == LAST_CNT);
  assign carry_new = maj3(a_sr_reg[0], b_sr_reg[0], fa_carry);

  serial_fa_bit u_fa (
    .clk      (clk),
    .rst_n    (reset),
    .a        (a_sr_reg[0]),
    .b        (b_sr_reg[0]),
    .load     (fa_load),
    .cin_load (cin),
    .en       (fa_en),
    .s        (fa_s),
    .carry    (fa_carry)
  );

  // Right-shift networks: operands zero-fill from the top, the sum collects new bits at the top.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_shr[gi] = a_sr_reg[gi+1];
      assign b_shr[gi] = b_sr_reg[gi+1];
    end
  endgenerate
  assign a_shr[WIDTH-1] = 1'b0;
  assign b_shr[WIDTH-1] = 1'b0;
  assign s_sr_next      = {fa_s, s_sr_reg};

  // Next-state selection; the unused encoding falls back to idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand/sum shift registers and bit counter: loaded on acceptance, advanced while shifting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sr_reg <= '0;
      b_sr_reg <= '0;
      s_sr_reg <= '0;
      cnt_reg  <= '0;
    end else if (fa_load) begin
      a_sr_reg <= op_a;
      b_sr_reg <= op_b;
      s_sr_reg <= '0;
      cnt_reg  <= '0;
    end else if (fa_en) begin
      a_sr_reg <= a_shr;
      b_sr_reg <= b_shr;
      s_sr_reg <= s_sr_next[WIDTH-1:1];
      cnt_reg  <= cnt_reg + CNT_W'(1);
    end
  end

  // Result registers change only on the final shift edge so the previous result holds meanwhile.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if (last_bit) begin
      sum_reg  <= s_sr_next;
      cout_reg <= carry_new;
    end
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = (state_reg == ST_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl with a result scoreboard per instance.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       reset;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  int tests = 0;
  int fails = 0;

  logic [4:0] q4[$];
  logic [8:0] q8[$];
  logic [4:0] prev4;
  logic [8:0] prev8;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .op_a(a4), .op_b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op_a(a8), .op_b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {cout,sum}.
  always @(negedge clk) begin
    if (reset === 1'b1 && done4 === 1'b1) begin
      if (q4.size() == 0) chk("dut4_unexpected_done", 64'(done4), 64'(0));
      else chk("dut4_result", 64'({cout4, sum4}), 64'(q4.pop_front()));
    end
    if (reset === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) chk("dut8_unexpected_done", 64'(done8), 64'(0));
      else chk("dut8_result", 64'({cout8, sum8}), 64'(q8.pop_front()));
    end
  end

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int k;
    logic [4:0] e;
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    e = {1'b0, a} + {1'b0, b} + 5'(c);
    q4.push_back(e);
    $display("[TB] w4 op a=%h b=%h cin=%0d expect cout=%0d sum=%h", a, b, c, e[4], e[3:0]);
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    k = 0;
    while (done4 !== 1'b1 && k < 20) begin
      chk("dut4_busy_during_op", 64'(busy4), 64'(1));
      chk("dut4_sum_hold", 64'({cout4, sum4}), 64'(prev4));
      @(negedge clk);
      k++;
    end
    chk("dut4_done_latency", 64'(k), 64'(4));
    chk("dut4_busy_at_done", 64'(busy4), 64'(1));
    prev4 = e;
    @(negedge clk);
    chk("dut4_busy_after", 64'(busy4), 64'(0));
    chk("dut4_done_one_cycle", 64'(done4), 64'(0));
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int k;
    logic [8:0] e;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    e = {1'b0, a} + {1'b0, b} + 9'(c);
    q8.push_back(e);
    $display("[TB] w8 op a=%h b=%h cin=%0d expect cout=%0d sum=%h", a, b, c, e[8], e[7:0]);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    k = 0;
    while (done8 !== 1'b1 && k < 30) begin
      chk("dut8_sum_hold", 64'({cout8, sum8}), 64'(prev8));
      @(negedge clk);
      k++;
    end
    chk("dut8_done_latency", 64'(k), 64'(8));
    prev8 = e;
    @(negedge clk);
    chk("dut8_busy_after", 64'(busy8), 64'(0));
  endtask

  initial begin
    reset = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    prev4 = '0; prev8 = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy4", 64'(busy4), 64'(0));
    chk("rst_done4", 64'(done4), 64'(0));
    chk("rst_result4", 64'({cout4, sum4}), 64'(0));
    chk("rst_busy8", 64'(busy8), 64'(0));
    chk("rst_result8", 64'({cout8, sum8}), 64'(0));
    reset = 1'b1;

    // Directed additions
    run4(4'b1010, 4'b1010, 1'b0);
    run4(4'b1100, 4'b1101, 1'b0);
    run4(4'b1111, 4'b0000, 1'b1);

    // start held high: one acceptance every 6 cycles, operands changing every cycle
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      start4 = 1'b1;
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      chk("held_busy", 64'(busy4), 64'(k % 6 != 0));
      chk("held_done", 64'(done4), 64'(k % 6 == 5));
      if (k % 6 == 0) begin
        prev4 = {1'b0, a4} + {1'b0, b4} + 5'(cin4);
        q4.push_back(prev4);
        $display("[TB] w4 held accept k=%0d a=%h b=%h cin=%0d", k, a4, b4, cin4);
      end
    end
    @(negedge clk);
    start4 = 1'b0;
    chk("held_all_results", 64'(q4.size()), 64'(0));
    chk("held_idle_after", 64'(busy4), 64'(0));

    // Reset two edges into the shift phase
    @(negedge clk);
    a4 = 4'b0111; b4 = 4'b0110; cin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", 64'(busy4), 64'(1));
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy4), 64'(0));
    chk("abort_done", 64'(done4), 64'(0));
    chk("abort_result", 64'({cout4, sum4}), 64'(0));
    $display("[TB] w4 reset asserted mid-operation");
    prev4 = '0; prev8 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done4), 64'(0));
    end
    run4(4'b0111, 4'b0110, 1'b1);

    // 8-bit instance
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hA5, 8'h5A, 1'b1);
    run8(8'h80, 8'h80, 1'b0);

    @(negedge clk);
    chk("final_q4_empty", 64'(q4.size()), 64'(0));
    chk("final_q8_empty", 64'(q8.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
